// File: rtl/sobel_stream_ctrl.sv
// sobel_stream_ctrl: frame sequencer around sobel_detector; tracks geometry, tags and
// border-masks detector output, flags geometry errors, drains and counts frames.
module sobel_stream_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int LINE_WIDTH    = 640,
  parameter int FRAME_HEIGHT  = 480,
  parameter int SOBEL_LATENCY = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic                  i_s_valid,
  output logic                  o_s_ready,
  input  logic [DATA_WIDTH-1:0] i_s_data,
  input  logic                  i_s_sof,
  input  logic                  i_s_eol,
  output logic                  o_sob_valid,
  output logic [DATA_WIDTH-1:0] o_sob_data,
  output logic                  o_sob_eol,
  input  logic                  i_sob_valid,
  input  logic [DATA_WIDTH-1:0] i_sob_data,
  output logic                  o_m_valid,
  output logic [DATA_WIDTH-1:0] o_m_data,
  output logic                  o_m_sof,
  output logic                  o_m_eol,
  output logic                  o_frame_done,
  output logic [15:0]           o_frame_cnt,
  output logic [2:0]            o_err
);
  localparam int CW  = $clog2(LINE_WIDTH);
  localparam int RW  = $clog2(FRAME_HEIGHT);
  localparam int DCW = $clog2(SOBEL_LATENCY + 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic [CW-1:0] col, col_nx, eff_col;
  logic [RW-1:0] row, row_nx, eff_row;
  logic [DCW-1:0] drain_cnt, drain_nx;
  logic [SOBEL_LATENCY-1:0][2:0] tag;
  logic [2:0] tag_in, tag_out;
  logic accept, run, start, sof_mid, restart, last_col, eol_pos, last_px;
  logic early_eol, missing_eol, done_nx;
  always_comb begin
    accept      = i_s_valid & o_s_ready;
    run         = state == RUN;
    start       = (state == IDLE) & i_s_sof & i_enable;
    sof_mid     = run & i_s_sof & ((row != '0) | (col != '0));
    restart     = start | sof_mid;
    // a SOF (fresh or mid-frame) always lands at (0,0)
    eff_row     = restart ? '0 : row;
    eff_col     = restart ? '0 : col;
    last_col    = eff_col == CW'(LINE_WIDTH - 1);
    eol_pos     = last_col | i_s_eol;
    last_px     = eol_pos & (eff_row == RW'(FRAME_HEIGHT - 1));
    o_sob_valid = accept & (run | start);
    o_sob_data  = i_s_data;
    o_sob_eol   = o_sob_valid & eol_pos;
    early_eol   = accept & run & i_s_eol & ~last_col;
    missing_eol = accept & run & last_col & ~i_s_eol;
    tag_in      = o_sob_valid ? {(eff_row < RW'(2)) | (eff_col < CW'(2)),
                                 (eff_row == '0) & (eff_col == '0), eol_pos} : 3'b000;
    tag_out     = tag[SOBEL_LATENCY-1];
  end
  always_comb begin
    state_nx = state;
    row_nx   = row;
    col_nx   = col;
    drain_nx = drain_cnt;
    done_nx  = 1'b0;
    if (o_sob_valid) begin
      row_nx = eol_pos ? eff_row + 1'b1 : eff_row;
      col_nx = eol_pos ? '0 : eff_col + 1'b1;
      state_nx = RUN;
      if (last_px) begin
        state_nx = DRAIN;
        row_nx   = '0;
        col_nx   = '0;
        drain_nx = DCW'(SOBEL_LATENCY - 1);
      end
    end
    if (state == DRAIN) begin
      drain_nx = drain_cnt - 1'b1;
      if (drain_cnt == '0) begin
        state_nx = IDLE;
        done_nx  = 1'b1;
      end
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      row          <= '0;
      col          <= '0;
      drain_cnt    <= '0;
      tag          <= '0;
      o_s_ready    <= 1'b0;
      o_m_valid    <= 1'b0;
      o_m_data     <= '0;
      o_m_sof      <= 1'b0;
      o_m_eol      <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_cnt  <= '0;
      o_err        <= '0;
    end else begin
      state        <= state_nx;
      row          <= row_nx;
      col          <= col_nx;
      drain_cnt    <= drain_nx;
      tag[0]       <= tag_in;
      for (int i = 1; i < SOBEL_LATENCY; i++) tag[i] <= tag[i-1];
      o_s_ready    <= state_nx != DRAIN;
      o_m_valid    <= i_sob_valid;
      o_m_data     <= (i_sob_valid & ~tag_out[2]) ? i_sob_data : '0;
      o_m_sof      <= i_sob_valid & tag_out[1];
      o_m_eol      <= i_sob_valid & tag_out[0];
      o_frame_done <= done_nx;
      o_frame_cnt  <= o_frame_cnt + 16'(done_nx);
      o_err        <= o_err | {accept & sof_mid, missing_eol, early_eol};
    end
  end
endmodule

// File: tb/tb_sobel_stream_ctrl.sv
// tb_sobel_stream_ctrl: random-stimulus scoreboard bench with a stub detector and a
// position-tracking frame model.
module tb_sobel_stream_ctrl;
  localparam int DW = 8, LW = 8, FH = 4, LAT = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic en = 1'b1, s_valid = 1'b0, s_sof = 1'b0, s_eol = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic s_ready, sob_valid, sob_eol, m_valid, m_sof, m_eol, frame_done;
  logic [DW-1:0] sob_data, m_data, sob_d_in;
  logic [15:0] frame_cnt;
  logic [2:0] err;
  logic [LAT-1:0] dv;
  logic [DW-1:0] dd [LAT];
  typedef struct {logic [DW-1:0] d; logic s; logic e; int t;} exp_t;
  exp_t q[$];
  int cyc = 0, n_chk = 0, n_fail = 0, n_out = 0, n_done = 0;
  bit m_act = 0;
  int m_r = 0, m_c = 0, m_frames = 0;
  logic [2:0] m_err = '0;

  sobel_stream_ctrl #(.DATA_WIDTH(DW), .LINE_WIDTH(LW), .FRAME_HEIGHT(FH), .SOBEL_LATENCY(LAT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_s_valid(s_valid), .o_s_ready(s_ready),
    .i_s_data(s_data), .i_s_sof(s_sof), .i_s_eol(s_eol), .o_sob_valid(sob_valid),
    .o_sob_data(sob_data), .o_sob_eol(sob_eol), .i_sob_valid(dv[LAT-1]), .i_sob_data(sob_d_in),
    .o_m_valid(m_valid), .o_m_data(m_data), .o_m_sof(m_sof), .o_m_eol(m_eol),
    .o_frame_done(frame_done), .o_frame_cnt(frame_cnt), .o_err(err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // stand-in detector: fixed latency, recognisable data transform
  assign sob_d_in = dd[LAT-1] ^ 8'h5A;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dv <= '0;
      for (int i = 0; i < LAT; i++) dd[i] <= '0;
    end else begin
      dv <= {dv[LAT-2:0], sob_valid};
      dd[0] <= sob_data;
      for (int i = 1; i < LAT; i++) dd[i] <= dd[i-1];
    end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    if (frame_done) n_done++;
    if (m_valid) begin
      exp_t e;
      n_out++;
      if (q.size() == 0) check("unexpected_m_valid", 1, 0);
      else begin
        e = q.pop_front();
        check("m_data", m_data, e.d);
        check("m_sof", m_sof, e.s);
        check("m_eol", m_eol, e.e);
        check("latency", cyc - e.t, LAT + 1);
      end
    end
  end

  task automatic px(bit sof, bit eol, logic [DW-1:0] d, bit e_in = 1);
    bit pass = 0, te;
    int w = 0;
    if ($urandom_range(0, 3) == 0) begin s_valid = 0; @(negedge clk); end
    while (!s_ready && w < 50) begin s_valid = 0; @(negedge clk); w++; end
    if (!s_ready) check("ready_timeout", 0, 1);
    s_valid = 1; s_sof = sof; s_eol = eol; s_data = d; en = e_in;
    if (!m_act) begin
      if (sof && e_in) begin m_act = 1; m_r = 0; m_c = 0; pass = 1; end
    end else begin
      pass = 1;
      if (sof && (m_r != 0 || m_c != 0)) begin m_err[2] = 1; m_r = 0; m_c = 0; end
      if (eol && m_c < LW - 1) m_err[0] = 1;
      if (!eol && m_c == LW - 1) m_err[1] = 1;
    end
    te = eol || m_c == LW - 1;
    if (pass) begin
      q.push_back('{d: (m_r < 2 || m_c < 2) ? 8'h00 : d ^ 8'h5A, s: m_r == 0 && m_c == 0, e: te, t: cyc});
      if (te) begin
        if (m_r == FH - 1) begin m_act = 0; m_frames++; end
        else m_r++;
        m_c = 0;
      end else m_c++;
    end
    #1;
    check("sob_valid", sob_valid, pass);
    if (pass) check("sob_eol", sob_eol, te);
    @(negedge clk);
    s_valid = 0; s_sof = 0; s_eol = 0;
  endtask

  // kind: 0 random, 1 ramp, 2 vertical step
  task automatic frame(int kind = 0, int early_r = -1, int miss_r = -1);
    for (int r = 0; r < FH; r++)
      for (int c = 0; c < LW; c++) begin
        logic [DW-1:0] d;
        bit e, ee;
        d = kind == 1 ? DW'(r * LW + c) : kind == 2 ? (c < 4 ? 8'd0 : 8'd200) : DW'($urandom);
        ee = r == early_r && c == 5;
        e = (c == LW - 1 && r != miss_r) || ee;
        px(r == 0 && c == 0, e, d, (r == 0 && c == 0) ? 1'b1 : 1'($urandom_range(0, 1)));
        if (ee) break;
      end
  endtask

  task automatic settle();
    repeat (LAT + 4) @(negedge clk);
    check("queue_drained", q.size(), 0);
    check("frame_cnt", frame_cnt, m_frames);
    check("frame_done_pulses", n_done, m_frames);
    check("err", err, m_err);
  endtask

  initial begin
    int o0, f0, w;
    repeat (3) @(negedge clk);
    check("reset_outputs", {s_ready, sob_valid, sob_eol, sob_data, m_valid, m_data, m_sof, m_eol,
                            frame_done, frame_cnt, err}, 0);
    rst_n = 1;
    o0 = n_out;
    frame(1);
    w = 0;
    while (!s_ready && w < 20) begin @(negedge clk); w++; end
    check("drain_cycles", w, LAT);
    settle();
    check("frame1_outputs", n_out - o0, LW * FH);
    check("frame1_cnt", frame_cnt, 1);
    frame(2);
    settle();
    for (int i = 0; i < 3; i++) px(0, i == 2, DW'($urandom));
    px(1, 0, DW'($urandom), 0);
    frame(0);
    settle();
    frame(0, 1);
    settle();
    check("early_eol_err", err, 3'b001);
    frame(0, -1, 2);
    settle();
    f0 = m_frames;
    for (int i = 0; i < 2 * LW + 3; i++) px(i == 0, i % LW == LW - 1, DW'($urandom));
    frame(0);
    settle();
    check("sof_mid_err", err[2], 1);
    check("sof_mid_cnt", frame_cnt, f0 + 1);
    for (int i = 0; i < 10; i++) px(i == 0, i % LW == LW - 1, DW'($urandom));
    rst_n = 0; s_data = '0; s_valid = 0; s_sof = 0; s_eol = 0;
    q.delete(); m_act = 0; m_r = 0; m_c = 0; m_err = '0; m_frames = 0; n_done = 0;
    repeat (2) @(negedge clk);
    check("midrun_reset_outputs", {s_ready, sob_valid, sob_eol, sob_data, m_valid, m_data, m_sof, m_eol,
                                   frame_done, frame_cnt, err}, 0);
    rst_n = 1;
    frame(0);
    frame(0);
    settle();
    check("post_reset_cnt", frame_cnt, 2);
    check("post_reset_err", err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
